mem_readout: RTL and testbench

MEM_READOUT -- requirements
Module: mem_readout

---
 rtl/mem_readout.sv | 113 +++++++++++
 tb/tb_mem_readout.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_readout.sv
// Streams word_count consecutive memory words starting at base_addr out over a valid/ready port.
// One word in flight at a time: ISSUE -> WAIT -> PRESENT, so each word costs 3 cycles plus any stall.
module mem_readout #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              mem_rd,
  output logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PRESENT,
    DONE
  } state_t;

  state_t           state;
  logic [31:0]      cur_addr;
  logic [CNT_W-1:0] remaining;

  assign mem_addr = cur_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= 32'd0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      mem_rd    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (word_count != '0) begin
              cur_addr  <= base_addr;
              remaining <= word_count;
              mem_rd    <= 1'b1;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              // Empty run: complete immediately, never touch memory or the stream.
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        ISSUE: begin
          mem_rd <= 1'b0;
          state  <= WAIT;
        end

        WAIT: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
          out_last  <= (remaining == CNT_W'(1));
          state     <= PRESENT;
        end

        PRESENT: begin
          if (out_ready) begin
            remaining <= remaining - CNT_W'(1);
            cur_addr  <= cur_addr + 32'd1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (remaining == CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem_rd <= 1'b1;
              state  <= ISSUE;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          mem_rd    <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_readout.sv
// Directed bench for mem_readout: stimulus pushes expected addresses/words, a negedge monitor pops and checks.
module tb_mem_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit zero_ok = 1'b0;

  logic [31:0] exp_addr[$];
  logic [32:0] exp_word[$];

  always #5 clk = ~clk;

  mem_readout #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .word_count(word_count),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h10: mem_val = 32'hA;
      32'h11: mem_val = 32'hB;
      32'h12: mem_val = 32'hC;
      default: mem_val = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory returns data one cycle after the read strobe; junk otherwise.
  always @(posedge clk) mem_rdata <= mem_rd ? mem_val(mem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  bit          stall_prev = 1'b0;
  bit          prev_last_xfer = 1'b0;
  logic [31:0] held;
  logic [32:0] w;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        if (exp_addr.size() == 0) chk("mem_rd_unexpected", 1, 0);
        else chk("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      if (!out_valid) chk("last_without_valid", out_last, 0);
      if (done) begin
        done_cnt++;
        chk("done_after_last", prev_last_xfer | zero_ok, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_word.size() == 0) chk("word_unexpected", 1, 0);
        else begin
          w = exp_word.pop_front();
          chk("out_data", out_data, w[31:0]);
          chk("out_last", out_last, w[32]);
        end
      end
      prev_last_xfer = out_valid && out_ready && out_last;
      stall_prev     = out_valid && !out_ready;
      held           = out_data;
    end else begin
      stall_prev     = 1'b0;
      prev_last_xfer = 1'b0;
    end
  end

  // Returns at posedge+1 of the cycle after acceptance (the ISSUE cycle for non-empty runs).
  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(b + i);
      exp_word.push_back({(i == int'(n) - 1), mem_val(b + i)});
    end
    @(posedge clk) #1;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk) #1;
    start = 1'b0; base_addr = 32'h0BAD_0BAD; word_count = 16'h7;
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < lim) begin @(negedge clk); n++; end
    chk("wait_valid_timeout", out_valid, 1);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    @(negedge clk);
    while (!done && n < lim) begin @(negedge clk); n++; end
    chk("wait_done_timeout", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = 32'h0; word_count = 16'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Basic run with first-word timing.
    do_start(32'h10, 16'd3);
    chk("t1_mem_rd", mem_rd, 1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    chk("t1_busy", busy, 1);
    @(posedge clk) #1;
    chk("t2_mem_rd", mem_rd, 0);
    chk("t2_out_valid", out_valid, 0);
    @(posedge clk) #1;
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data", out_data, 32'hA);
    wait_done(40);

    // Backpressure on the first word.
    out_ready = 1'b0;
    do_start(32'h20, 16'd2);
    wait_valid(20);
    chk("bp_data", out_data, 32'h5A5A_0020);
    chk("bp_last", out_last, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_no_mem_rd", mem_rd, 0);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    wait_done(40);

    // Zero length.
    zero_ok = 1'b1;
    do_start(32'h30, 16'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_mem_rd", mem_rd, 0);
    chk("zero_out_valid", out_valid, 0);
    @(posedge clk) #1;
    chk("zero_done_drop", done, 0);
    zero_ok = 1'b0;

    // Address wrap.
    do_start(32'hFFFF_FFFF, 16'd2);
    chk("wrap_first_addr", mem_addr, 32'hFFFF_FFFF);
    wait_done(40);

    // Reset during WAIT of word 2 of 4, with start asserted alongside reset.
    do_start(32'h40, 16'd4);
    repeat (4) @(posedge clk) #1;
    rst = 1'b1; start = 1'b1; base_addr = 32'h77; word_count = 16'd1;
    @(posedge clk) #1;
    rst = 1'b0; start = 1'b0;
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_words_left", exp_word.size(), 3);
    chk("mid_rst_addrs_left", exp_addr.size(), 2);
    exp_addr.delete();
    exp_word.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
      chk("post_rst_idle", busy, 0);
    end
    do_start(32'h10, 16'd3);
    wait_done(40);

    // Start while busy is ignored.
    do_start(32'h50, 16'd3);
    wait_valid(20);
    start = 1'b1; base_addr = 32'h99; word_count = 16'd5;
    @(posedge clk) #1;
    start = 1'b0;
    wait_done(40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_start_ignored", mem_rd | busy, 0);
    end

    chk("done_pulses", done_cnt, 6);
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("word_queue_empty", exp_word.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
